fifo_wr_arbiter: RTL



---
 rtl/fifo_arb_pkg.sv | 12 +
 rtl/fifo_wr_arbiter_if.sv | 32 +++
 rtl/fifo_rr_pick.sv | 30 +++
 rtl/fifo_wr_arbiter.sv | 116 +++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write-port arbiter: FSM state encoding and
// the width of the running write counter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int WORD_COUNT_W = 16;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-side signals of the write arbiter, bundled so the
// arbiter and its environment see one port.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int data_width = 8
) ();
  import fifo_arb_pkg::*;

  // Handshake: req[i] is the valid for slot i's word; ack[i] is the
  // same-cycle ready. A word moves only on a cycle where both are high, and a
  // producer holds req[i] and its data stable until then. Dropping req[i]
  // earlier withdraws the word.
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*data_width-1:0] req_data;
  logic [NUM_REQ-1:0]            ack;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [data_width-1:0]         fifo_wdata;
  logic [NUM_REQ-1:0]            grant;
  logic [WORD_COUNT_W-1:0]       word_count;

  modport master (
    output req, req_data, fifo_full,
    input  ack, fifo_wr_en, fifo_wdata, grant, word_count
  );

  modport slave (
    input  req, req_data, fifo_full,
    output ack, fifo_wr_en, fifo_wdata, grant, word_count
  );

endinterface

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: first requester found searching from
// last+1 upward (wrapping), with `last` itself checked last.
module fifo_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic [NUM_REQ-1:0]         pick,
  output logic [$clog2(NUM_REQ)-1:0] pick_idx,
  output logic                       any
);
  localparam int IDX_W = $clog2(NUM_REQ);

  always_comb begin
    pick     = '0;
    pick_idx = last;
    any      = 1'b0;
    // Walk from the farthest offset to the nearest so the nearest hit wins.
    for (int k = NUM_REQ; k >= 1; k--) begin
      int idx;
      idx = (int'(last) + k) % NUM_REQ;
      if (req[idx]) begin
        pick_idx = IDX_W'(idx);
        any      = 1'b1;
      end
    end
    if (any) pick[pick_idx] = 1'b1;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one async-FIFO write port among NUM_REQ
// producers; never writes while the FIFO reports full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int data_width = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic             wr_clk,
  input  logic             rst,
  fifo_wr_arbiter_if.slave bus,
  output arb_state_e       state_dbg
);
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0]  LAST_INIT = IDX_W'(NUM_REQ - 1);

  arb_state_e              state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [WORD_COUNT_W-1:0] word_count_q;

  logic [NUM_REQ-1:0]      pick;
  logic [IDX_W-1:0]        pick_idx;
  logic                    any_req;
  logic                    owner_req;
  logic                    accept;
  logic                    release_grant;
  logic [IDX_W-1:0]        data_sel;
  logic [data_width-1:0]   wdata;

  fifo_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req      (bus.req),
    .last     (last_q),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (any_req)
  );

  // last_q always holds the current owner's index while in GRANT.
  assign owner_req     = |(bus.req & grant_q);
  assign accept        = (state_q == GRANT) && owner_req && !bus.fifo_full;
  assign release_grant = (state_q == GRANT) &&
                         (!owner_req || (accept && (beat_q == LAST_BEAT)));
  assign data_sel      = (state_q == GRANT) ? last_q : '0;

  always_comb begin
    wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(data_sel) == i) wdata = bus.req_data[i*data_width +: data_width];
    end
  end

  assign bus.fifo_wr_en = accept;
  assign bus.fifo_wdata = wdata;
  assign bus.ack        = accept ? grant_q : '0;
  assign bus.grant      = grant_q;
  assign bus.word_count = word_count_q;
  assign state_dbg      = state_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          grant_d = pick;
          last_d  = pick_idx;
          beat_d  = '0;
        end
      end
      GRANT: begin
        // A stalled beat (fifo_full) neither counts nor releases the grant.
        if (release_grant) begin
          beat_d = '0;
          if (any_req) begin
            grant_d = pick;
            last_d  = pick_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (accept) begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_q       <= LAST_INIT;
      beat_q       <= '0;
      word_count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      if (accept) word_count_q <= word_count_q + 1'b1;
    end
  end

endmodule
